// File: rtl/issue_pkg.sv
// Shared types and default latencies for the Tomasulo issue stage.
// Used by issue_arbiter and cdb_resv_table.
package issue_pkg;

    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_LS   = 2'd1,
        UNIT_MULT = 2'd2,
        UNIT_DIV  = 2'd3
    } unit_e;

    localparam int INT_LAT    = 1;
    localparam int LS_LAT     = 1;
    localparam int MULT_LAT_D = 4;
    localparam int DIV_LAT_D  = 7;

endpackage

// File: rtl/cdb_resv_table.sv
// Tagged CDB reservation shift register.
// slot[i] set means the CDB is taken i cycles from now by owner[i].
module cdb_resv_table
    import issue_pkg::*;
#(
    parameter int DEPTH = DIV_LAT_D,
    localparam int IW = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift,
    input  logic [IW-1:0]        set_idx,
    input  logic [1:0]           set_owner,
    input  logic                 set_en,
    input  logic                 clear,
    output logic [DEPTH:0]       slot,
    output logic [DEPTH:0][1:0]  owner
);

    logic [DEPTH:0]      slot_q, slot_d;
    logic [DEPTH:0][1:0] owner_q, owner_d;

    // Advance the table one cycle, then book the new reservation
    always_comb begin
        slot_d  = slot_q;
        owner_d = owner_q;
        if (shift) begin
            slot_d  = {1'b0, slot_q[DEPTH:1]};
            owner_d = {2'b00, owner_q[DEPTH:1]};
        end
        if (set_en) begin
            slot_d[set_idx]  = 1'b1;
            owner_d[set_idx] = set_owner;
        end
        if (clear) begin
            slot_d  = '0;
            owner_d = '0;
        end
    end

    // Table state; reset drops every reservation at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q  <= '0;
            owner_q <= '0;
        end else begin
            slot_q  <= slot_d;
            owner_q <= owner_d;
        end
    end

    assign slot  = slot_q;
    assign owner = owner_q;

endmodule

// File: rtl/issue_arbiter.sv
// Single-issue CDB-collision-free arbiter over INT/LS/MULT/DIV queues.
// Define ISSUE_ARB_RR_EN to alternate INT/LS ties (default: INT wins).
module issue_arbiter
    import issue_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_D,
    parameter int DIV_LAT  = DIV_LAT_D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_int,
    input  logic       req_ls,
    input  logic       req_mult,
    input  logic       req_div,
    input  logic       issue_stall,
    input  logic       flush,
    output logic       gnt_int,
    output logic       gnt_ls,
    output logic       gnt_mult,
    output logic       gnt_div,
    output logic       cdb_valid,
    output logic [1:0] cdb_sel,
    output logic       div_busy
);

    localparam int IW = $clog2(DIV_LAT + 1);
    localparam int CW = (IW > 3) ? IW : 3;

    generate
        if (!(MULT_LAT > 1 && MULT_LAT < DIV_LAT)) begin : g_lat_chk
            $error("issue_arbiter: need 1 < MULT_LAT < DIV_LAT");
        end
    endgenerate

    logic [DIV_LAT:0]      slot;
    logic [DIV_LAT:0][1:0] owner;
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic                  div_gnt_q;
    logic                  ok;
    logic                  el_int, el_ls, el_mult, el_div;
    logic                  prefer_ls;
    logic                  set_en;
    logic [IW-1:0]         set_idx;
    unit_e                 set_owner;
    logic                  unused_tbl;

    assign div_busy = (div_cnt_q != '0) | div_gnt_q;

    assign ok      = rst & ~issue_stall & ~flush;
    assign el_div  = ok & req_div  & ~slot[DIV_LAT] & ~div_busy;
    assign el_mult = ok & req_mult & ~slot[MULT_LAT];
    assign el_int  = ok & req_int  & ~slot[INT_LAT];
    assign el_ls   = ok & req_ls   & ~slot[LS_LAT];

    assign gnt_div  = el_div;
    assign gnt_mult = el_mult & ~el_div;
    assign gnt_int  = el_int & ~el_div & ~el_mult
                    & ~(el_ls & prefer_ls);
    assign gnt_ls   = el_ls & ~el_div & ~el_mult
                    & ~(el_int & ~prefer_ls);

`ifdef ISSUE_ARB_RR_EN
    logic rr_q;

    // Last INT/LS winner yields the next tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 1'b0;
        end else if (gnt_int) begin
            rr_q <= 1'b1;
        end else if (gnt_ls) begin
            rr_q <= 1'b0;
        end
    end

    assign prefer_ls = rr_q;
`else
    assign prefer_ls = 1'b0;
`endif

    // Book the CDB slot the granted unit will write back into
    always_comb begin
        set_en    = 1'b1;
        set_idx   = '0;
        set_owner = UNIT_INT;
        unique case (1'b1)
            gnt_div: begin
                set_idx   = IW'(DIV_LAT - 1);
                set_owner = UNIT_DIV;
            end
            gnt_mult: begin
                set_idx   = IW'(MULT_LAT - 1);
                set_owner = UNIT_MULT;
            end
            gnt_int: begin
                set_idx   = IW'(INT_LAT - 1);
                set_owner = UNIT_INT;
            end
            gnt_ls: begin
                set_idx   = IW'(LS_LAT - 1);
                set_owner = UNIT_LS;
            end
            default: set_en = 1'b0;
        endcase
    end

    // Divider occupancy countdown, reloaded on each DIV grant
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end
        if (gnt_div) begin
            div_cnt_d = CW'(DIV_LAT - 1);
        end
        if (flush) begin
            div_cnt_d = '0;
        end
    end

    // Divider state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            div_gnt_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            div_gnt_q <= gnt_div;
        end
    end

    cdb_resv_table #(
        .DEPTH(DIV_LAT)
    ) u_tbl (
        .clk      (clk),
        .rst      (rst),
        .shift    (1'b1),
        .set_idx  (set_idx),
        .set_owner(set_owner),
        .set_en   (set_en),
        .clear    (flush),
        .slot     (slot),
        .owner    (owner)
    );

    assign cdb_valid  = slot[0];
    assign cdb_sel    = slot[0] ? owner[0] : 2'b00;
    assign unused_tbl = ^{slot, owner};

endmodule

// File: tb/tb_issue_arbiter.sv
// Randomized + directed bench for issue_arbiter against a
// cycle-calendar model of CDB bookings and divider availability.
module tb_issue_arbiter;
    import issue_pkg::*;

    localparam int ML = 4;
    localparam int DL = 7;
    localparam int NC = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_int = 0, req_ls = 0, req_mult = 0, req_div = 0;
    logic       issue_stall = 0, flush = 0;
    logic       gnt_int, gnt_ls, gnt_mult, gnt_div;
    logic       cdb_valid, div_busy;
    logic [1:0] cdb_sel;

    always #5 clk = ~clk;

    issue_arbiter #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .rst(rst),
        .req_int(req_int), .req_ls(req_ls),
        .req_mult(req_mult), .req_div(req_div),
        .issue_stall(issue_stall), .flush(flush),
        .gnt_int(gnt_int), .gnt_ls(gnt_ls),
        .gnt_mult(gnt_mult), .gnt_div(gnt_div),
        .cdb_valid(cdb_valid), .cdb_sel(cdb_sel),
        .div_busy(div_busy)
    );

    int checks = 0;
    int failures = 0;

    // model: owner booked on the CDB at absolute cycle, -1 if free
    int booked [NC + 16];
    int div_free = 0;
    int cyc = 0;
    bit rr_ls = 0;

    logic [3:0] o_gnt;
    logic       o_cv, o_busy;
    logic [1:0] o_sel;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // r = {div, mult, ls, int}
    task automatic step(input bit [3:0] r, input bit st,
                        input bit fl, input bit rs);
        bit [3:0] el, g;
        int lat [4];
        int ex_sel;
        bit ex_busy;
        lat = '{1, 1, ML, DL};
        @(negedge clk);
        rst = rs;
        {req_div, req_mult, req_ls, req_int} = r;
        issue_stall = st;
        flush = fl;
        #1;
        o_gnt  = {gnt_div, gnt_mult, gnt_ls, gnt_int};
        o_cv   = cdb_valid;
        o_sel  = cdb_sel;
        o_busy = div_busy;
        g = '0;
        ex_busy = 1'b0;
        if (!rs) begin
            for (int i = cyc; i < NC + 16; i++) booked[i] = -1;
            div_free = 0;
            rr_ls = 0;
        end else begin
            ex_busy = cyc < div_free;
            for (int u = 0; u < 4; u++)
                el[u] = r[u] && !st && !fl && booked[cyc + lat[u]] < 0
                        && !(u == 3 && ex_busy);
            if (el[3]) g[3] = 1'b1;
            else if (el[2]) g[2] = 1'b1;
            else if (el[0] && el[1]) g[rr_ls ? 1 : 0] = 1'b1;
            else g[1:0] = el[1:0];
        end
        ex_sel = booked[cyc];
        chk("gnt", 32'(o_gnt), 32'(g));
        chk("cdb_valid", 32'(o_cv), 32'(ex_sel >= 0));
        chk("cdb_sel", 32'(o_sel), (ex_sel >= 0) ? 32'(ex_sel) : 32'd0);
        chk("div_busy", 32'(o_busy), 32'(ex_busy));
        if (rs) begin
            for (int u = 0; u < 4; u++)
                if (g[u]) booked[cyc + lat[u]] = u;
            if (g[3]) div_free = cyc + DL;
`ifdef ISSUE_ARB_RR_EN
            if (g[0]) rr_ls = 1;
            if (g[1]) rr_ls = 0;
`endif
            if (fl) begin
                for (int i = cyc + 1; i < NC + 16; i++) booked[i] = -1;
                div_free = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 0, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < NC + 16; i++) booked[i] = -1;
        #1 rst = 1'b0;

        // reset with all requests asserted
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 0, 0, 0);
            chk("rst_gnt", 32'(o_gnt), 32'd0);
            chk("rst_cdb", 32'(o_cv), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
        end
        step(4'b1111, 0, 0, 1);
        chk("rel_div", 32'(o_gnt), 32'h8);
        idle(6);
        step(4'b0000, 0, 0, 1);
        chk("rel_cdb", 32'({o_cv, o_sel}), 32'h7);

        // INT/LS tie right after reset
        step(4'b0000, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(4'b0011, 0, 0, 1);
`ifdef ISSUE_ARB_RR_EN
            chk("tie", 32'(o_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
`else
            chk("tie", 32'(o_gnt), 32'h1);
`endif
        end

        // collision with a booked MULT slot
        idle(10);
        step(4'b0100, 0, 0, 1);
        chk("col_mult", 32'(o_gnt), 32'h4);
        idle(2);
        step(4'b0001, 0, 0, 1);
        chk("col_deny", 32'(o_gnt), 32'h0);
        step(4'b0001, 0, 0, 1);
        chk("col_int", 32'(o_gnt), 32'h1);

        // divider occupancy
        idle(10);
        for (int k = 0; k < 15; k++) begin
            step(4'b1000, 0, 0, 1);
            if (k == 0 || k == 7 || k == 14)
                chk("occ_gnt", 32'(o_gnt), 32'h8);
            if (k >= 1 && k <= 6) begin
                chk("occ_busy", 32'(o_busy), 32'd1);
                chk("occ_hold", 32'(o_gnt), 32'h0);
            end
        end

        // flush drops reservations and frees the divider
        idle(10);
        step(4'b1000, 0, 0, 1);
        chk("fl_div", 32'(o_gnt), 32'h8);
        step(4'b0100, 0, 0, 1);
        chk("fl_mult", 32'(o_gnt), 32'h4);
        step(4'b1111, 0, 1, 1);
        chk("fl_gnt", 32'(o_gnt), 32'h0);
        step(4'b1000, 0, 0, 1);
        chk("fl_busy", 32'(o_busy), 32'd0);
        chk("fl_regnt", 32'(o_gnt), 32'h8);
        idle(1);
        step(4'b0000, 0, 0, 1);
        chk("fl_cdb5", 32'(o_cv), 32'd0);
        idle(1);
        step(4'b0000, 0, 0, 1);
        chk("fl_cdb7", 32'(o_cv), 32'd0);

        // stall blocks grants, booked MULT still broadcasts
        idle(10);
        step(4'b0100, 0, 0, 1);
        chk("st_mult", 32'(o_gnt), 32'h4);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1, 0, 1);
            chk("st_gnt", 32'(o_gnt), 32'h0);
        end
        step(4'b0000, 0, 0, 1);
        chk("st_cdb", 32'({o_cv, o_sel}), 32'h6);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step(4'($urandom), ($urandom % 8) == 0,
                 ($urandom % 16) == 0, ($urandom % 100) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
